// File: rtl/pool_ctrl_if.sv
// DRAM port bundle shared by the pooling and conv controllers.
// The controller drives the master side and DRAM drives the slave side.
interface pool_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18
);
    logic [DATA_WIDTH-1:0] data_in;
    logic [ADDR_WIDTH-1:0] addr_in;
    logic                  dram_en_rd;
    logic [ADDR_WIDTH-1:0] addr_out;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  dram_en_wr;

    modport master (
        input  data_in,
        output addr_in, dram_en_rd, addr_out, data_out, dram_en_wr
    );

    modport slave (
        output data_in,
        input  addr_in, dram_en_rd, addr_out, data_out, dram_en_wr
    );
endinterface

// File: rtl/pool_ctrl.sv
// 2x2 stride-2 signed max-pool sequencer: reads each window from DRAM,
// reduces it to one word, and writes the result back to the pooled map.
module pool_ctrl #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 18,
    parameter logic [ADDR_WIDTH-1:0] SRC_BASE   = 18'd131072,
    parameter logic [ADDR_WIDTH-1:0] DST_BASE   = 18'd196608
) (
    input  logic        clk,
    input  logic        srstn,
    input  logic        enable,
    input  logic [4:0]  num_chnl,
    input  logic [5:0]  fmap_height,
    input  logic [5:0]  fmap_width,
    pool_ctrl_if.master dram,
    output logic        busy,
    output logic        done
);
    localparam logic [4:0] S_IDLE = 5'b00001;
    localparam logic [4:0] S_RD   = 5'b00010;
    localparam logic [4:0] S_WAIT = 5'b00100;
    localparam logic [4:0] S_WR   = 5'b01000;
    localparam logic [4:0] S_DONE = 5'b10000;

    logic [4:0]            state;
    logic [4:0]            chnl;
    logic [3:0]            wy, wx;
    logic [1:0]            k;
    logic [4:0]            c_lat, hh, ww;
    logic [DATA_WIDTH-1:0] max_q;

    logic wx_last, wy_last, chnl_last;
    logic cap, first;

    always_comb begin
        wx_last   = ({1'b0, wx} == ww - 5'd1);
        wy_last   = ({1'b0, wy} == hh - 5'd1);
        chnl_last = (chnl == c_lat - 5'd1);
        // read data trails the strobe by one cycle, so sample k arrives at step k+1
        cap       = (state == S_RD && k != 2'd0) || state == S_WAIT;
        first     = (state == S_RD && k == 2'd1);
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            state <= S_IDLE;
            chnl  <= '0;
            wy    <= '0;
            wx    <= '0;
            k     <= '0;
            c_lat <= '0;
            hh    <= '0;
            ww    <= '0;
            max_q <= '0;
        end else begin
            if (cap && (first || $signed(dram.data_in) > $signed(max_q)))
                max_q <= dram.data_in;

            case (state)
                S_IDLE: begin
                    if (enable) begin
                        c_lat <= num_chnl;
                        hh    <= fmap_height[5:1];
                        ww    <= fmap_width[5:1];
                        chnl  <= '0;
                        wy    <= '0;
                        wx    <= '0;
                        k     <= '0;
                        if (num_chnl == 5'd0 || fmap_height < 6'd2 || fmap_width < 6'd2)
                            state <= S_DONE;
                        else
                            state <= S_RD;
                    end
                end
                S_RD: begin
                    k <= k + 2'd1;
                    if (k == 2'd3) state <= S_WAIT;
                end
                S_WAIT: state <= S_WR;
                S_WR: begin
                    state <= (wx_last && wy_last && chnl_last) ? S_DONE : S_RD;
                    if (wx_last) begin
                        wx <= '0;
                        if (wy_last) begin
                            wy   <= '0;
                            chnl <= chnl + 5'd1;
                        end else begin
                            wy <= wy + 4'd1;
                        end
                    end else begin
                        wx <= wx + 4'd1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        dram.addr_in    = '0;
        dram.dram_en_rd = 1'b0;
        dram.addr_out   = '0;
        dram.data_out   = '0;
        dram.dram_en_wr = 1'b0;
        busy            = (state != S_IDLE);
        done            = (state == S_DONE);
        if (state == S_RD) begin
            dram.dram_en_rd = 1'b1;
            // {chnl, y, x} with y = 2*wy + k[1], x = 2*wx + k[0]
            dram.addr_in    = SRC_BASE + ADDR_WIDTH'({chnl[3:0], wy, k[1], wx, k[0]});
        end
        if (state == S_WR) begin
            dram.dram_en_wr = 1'b1;
            dram.data_out   = max_q;
            dram.addr_out   = DST_BASE + ADDR_WIDTH'({chnl[3:0], 1'b0, wy, 1'b0, wx});
        end
    end
endmodule
